// File: rtl/inst_queue_pkg.sv
// Shared definitions for the fetch-side instruction queue: exception codes,
// the buffered entry layout and a small popcount helper.
package inst_queue_pkg;

  typedef enum logic [3:0] {
    EXCP_NONE = 4'd0,
    EXCP_ADEF = 4'd1,
    EXCP_TLBR = 4'd2,
    EXCP_PIF  = 4'd3,
    EXCP_PPI  = 4'd4
  } excp_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_br_taken;
    logic [31:0] pred_br_target;
    logic        have_excp;
    excp_t       excp_type;
  } ibuf_entry_t;

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/inst_queue_checker.sv
// Simulation-only invariants for inst_queue: handshake shapes and the
// head/tail/count pointer relationship.
module inst_queue_checker #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input logic             clk,
  input logic             reset,
  input logic [1:0]       in_valid,
  input logic [1:0]       out_accept,
  input logic [PTR_W-1:0] head,
  input logic [PTR_W-1:0] tail,
  input logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] COUNT_MAX = (PTR_W+1)'(DEPTH);

  a_in_valid_prefix: assert property (@(posedge clk) disable iff (reset)
    in_valid != 2'b10);

  a_out_accept_prefix: assert property (@(posedge clk) disable iff (reset)
    out_accept != 2'b10);

  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    count <= COUNT_MAX);

  a_ptr_consistent: assert property (@(posedge clk) disable iff (reset)
    PTR_W'(head + count[PTR_W-1:0]) == tail);

endmodule

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: accepts up to two in-order
// instructions per cycle and presents the two oldest entries to decode.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [1:0]       in_valid,
  output logic             in_ready,
  input  logic [1:0][31:0] in_pc,
  input  logic [1:0][31:0] in_inst,
  input  logic [1:0]       in_pred_br_taken,
  input  logic [1:0][31:0] in_pred_br_target,
  input  logic [1:0]       in_have_excp,
  input  excp_t [1:0]      in_excp_type,
  output logic [1:0]       out_valid,
  input  logic [1:0]       out_accept,
  output logic [1:0][31:0] out_pc,
  output logic [1:0][31:0] out_inst,
  output logic [1:0]       out_pred_br_taken,
  output logic [1:0][31:0] out_pred_br_target,
  output logic [1:0]       out_have_excp,
  output excp_t [1:0]      out_excp_type
);

  localparam logic [PTR_W:0] READY_LIMIT = (PTR_W+1)'(DEPTH - 2);

  ibuf_entry_t mem [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;

  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;
  logic             push;
  logic [1:0]       push_n;
  logic [1:0]       pop_n;
  ibuf_entry_t      in_e0;
  ibuf_entry_t      in_e1;
  ibuf_entry_t      rd_e0;
  ibuf_entry_t      rd_e1;

  // Ready depends only on registered occupancy so fetch never sees a path from decode.
  assign in_ready  = (count <= READY_LIMIT);
  assign out_valid = {(count >= (PTR_W+1)'(2)), (count >= (PTR_W+1)'(1))};

  assign head_p1 = head + PTR_W'(1);
  assign tail_p1 = tail + PTR_W'(1);
  assign push    = in_ready & in_valid[0];
  assign push_n  = push ? popcount2(in_valid) : 2'd0;
  assign pop_n   = popcount2(out_accept & out_valid);

  // Pack incoming slots into entry records.
  always_comb begin
    in_e0 = '{pc: in_pc[0], inst: in_inst[0], pred_br_taken: in_pred_br_taken[0],
              pred_br_target: in_pred_br_target[0], have_excp: in_have_excp[0],
              excp_type: in_excp_type[0]};
    in_e1 = '{pc: in_pc[1], inst: in_inst[1], pred_br_taken: in_pred_br_taken[1],
              pred_br_target: in_pred_br_target[1], have_excp: in_have_excp[1],
              excp_type: in_excp_type[1]};
  end

  // Pointer and occupancy update; flush wins over same-cycle push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop_n);
      tail  <= tail + PTR_W'(push_n);
      count <= count + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_n);
    end
  end

  // Entry storage write; payload needs no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[tail] <= in_e0;
      if (in_valid[1]) begin
        mem[tail_p1] <= in_e1;
      end
    end
  end

  assign rd_e0 = mem[head];
  assign rd_e1 = mem[head_p1];

  // Unpack the two oldest entries onto the decode-facing slots.
  always_comb begin
    out_pc             = {rd_e1.pc, rd_e0.pc};
    out_inst           = {rd_e1.inst, rd_e0.inst};
    out_pred_br_taken  = {rd_e1.pred_br_taken, rd_e0.pred_br_taken};
    out_pred_br_target = {rd_e1.pred_br_target, rd_e0.pred_br_target};
    out_have_excp      = {rd_e1.have_excp, rd_e0.have_excp};
    out_excp_type      = {rd_e1.excp_type, rd_e0.excp_type};
  end

  inst_queue_checker #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_checker (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .out_accept (out_accept),
    .head       (head),
    .tail       (tail),
    .count      (count)
  );

endmodule
